// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: control-word layout,
// writeback source codes, funct3 width codes and FSM states.
package mem_stage_pkg;

  localparam int CW_W        = 14;
  localparam int CW_BRANCH   = 13;
  localparam int CW_RF_WB    = 12;
  localparam int CW_MEM_WE   = 11;
  localparam int CW_WBSRC_HI = 10;
  localparam int CW_WBSRC_LO = 9;
  localparam int CW_PC_SRC   = 8;
  localparam int CW_RD_HI    = 7;
  localparam int CW_RD_LO    = 3;
  localparam int CW_F3_HI    = 2;
  localparam int CW_F3_LO    = 0;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads,
// plus misalignment and illegal-width detection.
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  adr_lo_i,
  input  logic        is_store_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic        illegal_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;
  assign shifted = rdata_i >> {adr_lo_i, 3'b000};

  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    illegal_o    = 1'b1;
    load_data_o  = '0;
    case (funct3_i)
      F3_B: begin
        be_o        = 4'b0001 << adr_lo_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = {{24{shifted[7]}}, shifted[7:0]};
        illegal_o   = 1'b0;
      end
      F3_H: begin
        be_o         = 4'b0011 << {adr_lo_i[1], 1'b0};
        wdata_o      = {2{store_data_i[15:0]}};
        load_data_o  = {{16{shifted[15]}}, shifted[15:0]};
        misaligned_o = adr_lo_i[0];
        illegal_o    = 1'b0;
      end
      F3_W: begin
        be_o         = 4'b1111;
        load_data_o  = rdata_i;
        misaligned_o = |adr_lo_i;
        illegal_o    = 1'b0;
      end
      // Unsigned widths exist only for loads.
      F3_BU: begin
        be_o        = 4'b0001 << adr_lo_i;
        load_data_o = {24'h0, shifted[7:0]};
        illegal_o   = is_store_i;
      end
      F3_HU: begin
        be_o         = 4'b0011 << {adr_lo_i[1], 1'b0};
        load_data_o  = {16'h0, shifted[15:0]};
        misaligned_o = adr_lo_i[0];
        illegal_o    = is_store_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: runs loads/stores on a req/gnt/rvalid port and
// produces one registered writeback beat per instruction.
//   state   | meaning
//   IDLE    | ready for a new instruction; pass-through and faults finish here
//   REQ     | dmem_req high, request fields held until gnt
//   WAIT    | load granted, waiting for rvalid
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [CW_W-1:0]   control_word_ex,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       calculated_adr,
  input  logic [31:0]       regfileb_ex,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_rf_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              mem_fault
);

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] adr_q, adr_d, sdata_q, sdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rf_wb_q, rf_wb_d, store_q, store_d;
  logic        wb_valid_q, wb_valid_d, wb_rf_we_q, wb_rf_we_d;
  logic        fault_q, fault_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        ex_rf_wb, ex_mem_we, ex_is_load;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_f3;
  logic        unused_ctl;

  assign ex_rf_wb   = control_word_ex[CW_RF_WB];
  assign ex_mem_we  = control_word_ex[CW_MEM_WE];
  assign ex_rd      = control_word_ex[CW_RD_HI:CW_RD_LO];
  assign ex_f3      = control_word_ex[CW_F3_HI:CW_F3_LO];
  assign ex_is_load = (control_word_ex[CW_WBSRC_HI:CW_WBSRC_LO] == WB_MEM) && !ex_mem_we;
  // Branch outcome and pc_src are consumed by fetch directly from execute.
  assign unused_ctl = control_word_ex[CW_BRANCH] ^ control_word_ex[CW_PC_SRC];

  logic        idle;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        al_mis, al_ill;

  assign idle = (state_q == ST_IDLE);

  // In IDLE the aligner judges the incoming access; afterwards the captured one.
  load_store_align u_align (
    .funct3_i     (idle ? ex_f3 : f3_q),
    .adr_lo_i     (idle ? calculated_adr[1:0] : adr_q[1:0]),
    .is_store_i   (idle ? ex_mem_we : store_q),
    .store_data_i (sdata_q),
    .rdata_i      (dmem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .misaligned_o (al_mis),
    .illegal_o    (al_ill),
    .load_data_o  (al_load)
  );

  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    adr_d      = adr_q;
    sdata_d    = sdata_q;
    rd_d       = rd_q;
    rf_wb_d    = rf_wb_q;
    store_d    = store_q;
    wb_valid_d = 1'b0;
    fault_d    = 1'b0;
    wb_rf_we_d = wb_rf_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (ex_is_load || ex_mem_we) begin
            if (al_mis || al_ill) begin
              wb_valid_d = 1'b1;
              fault_d    = 1'b1;
              wb_rf_we_d = 1'b0;
              wb_rd_d    = ex_rd;
              wb_data_d  = '0;
            end else begin
              f3_d    = ex_f3;
              adr_d   = calculated_adr;
              sdata_d = regfileb_ex;
              rd_d    = ex_rd;
              rf_wb_d = ex_rf_wb;
              store_d = ex_mem_we;
              state_d = ST_REQ;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_rf_we_d = ex_rf_wb && (ex_rd != 5'd0);
            wb_rd_d    = ex_rd;
            wb_data_d  = ALU_result;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          if (store_q) begin
            wb_valid_d = 1'b1;
            wb_rf_we_d = 1'b0;
            wb_rd_d    = rd_q;
            wb_data_d  = '0;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_rf_we_d = rf_wb_q && (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = al_load;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      f3_q       <= '0;
      adr_q      <= '0;
      sdata_q    <= '0;
      rd_q       <= '0;
      rf_wb_q    <= 1'b0;
      store_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      wb_rf_we_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      adr_q      <= adr_d;
      sdata_q    <= sdata_d;
      rd_q       <= rd_d;
      rf_wb_q    <= rf_wb_d;
      store_q    <= store_d;
      wb_valid_q <= wb_valid_d;
      fault_q    <= fault_d;
      wb_rf_we_q <= wb_rf_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign ex_ready   = idle;
  assign dmem_req   = (state_q == ST_REQ);
  assign dmem_we    = dmem_req && store_q;
  assign dmem_be    = dmem_req ? al_be : 4'b0000;
  assign dmem_addr  = dmem_req ? {adr_q[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata = dmem_we ? al_wdata : '0;
  assign wb_valid   = wb_valid_q;
  assign wb_rf_we   = wb_rf_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign mem_fault  = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [13:0] control_word_ex;
  logic [31:0] ALU_result, calculated_adr, regfileb_ex;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_rf_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .control_word_ex(control_word_ex), .ALU_result(ALU_result),
    .calculated_adr(calculated_adr), .regfileb_ex(regfileb_ex),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_fault(mem_fault)
  );

  function automatic logic [13:0] cw(input logic rf_wb, input logic mem_we,
                                     input logic [1:0] src, input logic [4:0] rd,
                                     input logic [2:0] f3);
    return {1'b0, rf_wb, mem_we, src, 1'b0, rd, f3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] adr, input logic [31:0] data,
                          input int gnt_delay, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    ex_valid = 1'b1;
    control_word_ex = cw(1'b0, 1'b1, 2'b00, 5'd0, f3);
    calculated_adr = adr;
    regfileb_ex = data;
    step();
    ex_valid = 1'b0;
    for (int i = 0; i <= gnt_delay; i++) begin
      chk("st_req", dmem_req, 1'b1);
      chk("st_we", dmem_we, 1'b1);
      chk("st_addr", dmem_addr, exp_addr);
      chk("st_be", dmem_be, exp_be);
      chk("st_wdata", dmem_wdata, exp_wdata);
      chk("st_ex_ready", ex_ready, 1'b0);
      chk("st_no_wb", wb_valid, 1'b0);
      dmem_gnt = (i == gnt_delay);
      step();
    end
    dmem_gnt = 1'b0;
    chk("st_wb_valid", wb_valid, 1'b1);
    chk("st_wb_rf_we", wb_rf_we, 1'b0);
    chk("st_fault", mem_fault, 1'b0);
    chk("st_req_drop", dmem_req, 1'b0);
    chk("st_ready_back", ex_ready, 1'b1);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] adr, input logic [4:0] rd,
                         input logic [31:0] rdata, input int rv_delay,
                         input logic [31:0] exp_data, input logic exp_we);
    ex_valid = 1'b1;
    control_word_ex = cw(1'b1, 1'b0, 2'b01, rd, f3);
    calculated_adr = adr;
    regfileb_ex = 32'h5555_5555;
    step();
    ex_valid = 1'b0;
    chk("ld_req", dmem_req, 1'b1);
    chk("ld_we", dmem_we, 1'b0);
    chk("ld_addr", dmem_addr, {adr[31:2], 2'b00});
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    for (int i = 0; i <= rv_delay; i++) begin
      chk("ld_wait_req", dmem_req, 1'b0);
      chk("ld_wait_ready", ex_ready, 1'b0);
      chk("ld_wait_no_wb", wb_valid, 1'b0);
      dmem_rvalid = (i == rv_delay);
      dmem_rdata = (i == rv_delay) ? rdata : 32'hDEAD_BEEF;
      step();
    end
    dmem_rvalid = 1'b0;
    chk("ld_wb_valid", wb_valid, 1'b1);
    chk("ld_wb_data", wb_data, exp_data);
    chk("ld_wb_rd", wb_rd, rd);
    chk("ld_wb_rf_we", wb_rf_we, exp_we);
    chk("ld_fault", mem_fault, 1'b0);
  endtask

  task automatic do_fault(input logic is_store, input logic [2:0] f3, input logic [31:0] adr);
    ex_valid = 1'b1;
    control_word_ex = is_store ? cw(1'b0, 1'b1, 2'b00, 5'd0, f3)
                               : cw(1'b1, 1'b0, 2'b01, 5'd3, f3);
    calculated_adr = adr;
    step();
    ex_valid = 1'b0;
    chk("flt_no_req", dmem_req, 1'b0);
    chk("flt_wb_valid", wb_valid, 1'b1);
    chk("flt_fault", mem_fault, 1'b1);
    chk("flt_rf_we", wb_rf_we, 1'b0);
    chk("flt_ready", ex_ready, 1'b1);
    step();
    chk("flt_pulse", mem_fault, 1'b0);
    chk("flt_no_req2", dmem_req, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0;
    control_word_ex = '0;
    ALU_result = '0;
    calculated_adr = '0;
    regfileb_ex = '0;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    #2;
    chk("rst_ex_ready", ex_ready, 1'b1);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_fault", mem_fault, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ALU pass-through, with branch/pc_src bits set to show they are ignored
    ex_valid = 1'b1;
    control_word_ex = cw(1'b1, 1'b0, 2'b00, 5'd5, 3'b000) | 14'h2100;
    ALU_result = 32'h0000_1234;
    step();
    chk("alu_wb_valid", wb_valid, 1'b1);
    chk("alu_wb_rd", wb_rd, 5'd5);
    chk("alu_wb_data", wb_data, 32'h0000_1234);
    chk("alu_rf_we", wb_rf_we, 1'b1);
    chk("alu_no_req", dmem_req, 1'b0);
    // Back-to-back accept in the same cycle as a beat
    control_word_ex = cw(1'b1, 1'b0, 2'b00, 5'd9, 3'b010);
    ALU_result = 32'hCAFE_0001;
    step();
    ex_valid = 1'b0;
    chk("alu2_wb_valid", wb_valid, 1'b1);
    chk("alu2_wb_rd", wb_rd, 5'd9);
    chk("alu2_wb_data", wb_data, 32'hCAFE_0001);
    step();
    chk("alu_pulse", wb_valid, 1'b0);
    chk("alu_hold_data", wb_data, 32'hCAFE_0001);
    chk("alu_hold_rd", wb_rd, 5'd9);

    // ALU op with rd = 0 never writes
    ex_valid = 1'b1;
    control_word_ex = cw(1'b1, 1'b0, 2'b00, 5'd0, 3'b000);
    ALU_result = 32'h0000_0077;
    step();
    ex_valid = 1'b0;
    chk("alu_rd0_valid", wb_valid, 1'b1);
    chk("alu_rd0_rf_we", wb_rf_we, 1'b0);

    // Stores
    do_store(3'b000, 32'h0000_0103, 32'h1234_56AB, 2, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
    do_store(3'b001, 32'h0000_0102, 32'h1234_BEEF, 0, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF);
    do_store(3'b010, 32'h0000_0104, 32'h8765_4321, 1, 32'h0000_0104, 4'b1111, 32'h8765_4321);
    do_store(3'b000, 32'h0000_0101, 32'h0000_0011, 0, 32'h0000_0100, 4'b0010, 32'h1111_1111);

    // Loads
    do_load(3'b000, 32'h0000_0202, 5'd7, 32'h0080_0000, 0, 32'hFFFF_FF80, 1'b1);
    do_load(3'b100, 32'h0000_0202, 5'd7, 32'h0080_0000, 0, 32'h0000_0080, 1'b1);
    do_load(3'b001, 32'h0000_0202, 5'd8, 32'h8001_0000, 2, 32'hFFFF_8001, 1'b1);
    do_load(3'b101, 32'h0000_0202, 5'd8, 32'h8001_0000, 1, 32'h0000_8001, 1'b1);
    do_load(3'b010, 32'h0000_0204, 5'd9, 32'hA5A5_1234, 0, 32'hA5A5_1234, 1'b1);
    do_load(3'b000, 32'h0000_0201, 5'd4, 32'h0000_7F00, 0, 32'h0000_007F, 1'b1);
    do_load(3'b010, 32'h0000_0300, 5'd0, 32'h1111_2222, 0, 32'h1111_2222, 1'b0);

    // Faults: misaligned and illegal widths
    do_fault(1'b0, 3'b010, 32'h0000_0206);
    do_fault(1'b0, 3'b001, 32'h0000_0201);
    do_fault(1'b1, 3'b011, 32'h0000_0200);
    do_fault(1'b1, 3'b100, 32'h0000_0200);
    do_fault(1'b0, 3'b110, 32'h0000_0200);

    // rvalid outside WAIT is ignored
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h1234_5678;
    step();
    dmem_rvalid = 1'b0;
    chk("stray_rvalid", wb_valid, 1'b0);

    // Reset during REQ drops dmem_req immediately
    ex_valid = 1'b1;
    control_word_ex = cw(1'b1, 1'b0, 2'b01, 5'd6, 3'b010);
    calculated_adr = 32'h0000_0400;
    step();
    ex_valid = 1'b0;
    chk("rreq_req", dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rreq_req_drop", dmem_req, 1'b0);
    chk("rreq_ready", ex_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset during WAIT; late rvalid afterwards produces no beat
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("rwait_ready_low", ex_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rwait_ready", ex_ready, 1'b1);
    chk("rwait_req", dmem_req, 1'b0);
    chk("rwait_wb", wb_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    chk("late_rvalid_wb", wb_valid, 1'b0);
    chk("late_rvalid_ready", ex_ready, 1'b1);
    step();
    chk("late_rvalid_wb2", wb_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage between the execute stage and register writeback. Consumes the execute stage's 14-bit control word, ALU result, computed address and store data. Runs load/store transactions on a req/gnt/rvalid data-memory port, handling byte-lane alignment and load sign extension. Presents one registered writeback beat per instruction and stalls upstream while a memory transaction is in flight.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_ready  out  1  stage can accept; high only in IDLE.
- control_word_ex  in  14  {branch_taken_ex, rf_wb, mem_we, wb_src[1:0], pc_src, rd[4:0], funct3[2:0]}.
- ALU_result  in  32  writeback value for non-load ops.
- calculated_adr  in  32  load/store byte address.
- regfileb_ex  in  32  store data.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_be  out  4  byte enables.
- dmem_addr  out  ADDR_W  word-aligned address ({adr[31:2], 2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data.
- wb_valid  out  1  one-cycle writeback beat.
- wb_rf_we  out  1  register-file write enable.
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback data.
- mem_fault  out  1  misaligned or illegal-width access, pulsed with wb_valid.

## Operation
- Load: wb_src == 2'b01 and mem_we == 0. Store: mem_we == 1. Everything else is a pass-through op.
- branch_taken_ex and pc_src are ignored here; fetch consumes them directly from execute.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on ex_valid & ex_ready, capture the inputs.
    - Pass-through: load the wb registers; stay in IDLE.
    - Load/store: go to REQ.
    - Misaligned or illegal access: no request; fault beat; stay in IDLE.
  - REQ: dmem_req = 1; addr, be, we and wdata held stable until gnt.
    - gnt on a store: emit wb beat (rf_we = 0); go to IDLE.
    - gnt on a load: go to WAIT.
  - WAIT: on rvalid, emit extended data; go to IDLE. rvalid is never earlier than the cycle after gnt.
- Alignment: halfword requires adr[0] = 0; word requires adr[1:0] = 0.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
  - Any other value is illegal and raises mem_fault.
- Store byte enables: SB = 4'b0001 << adr[1:0]; SH = 4'b0011 << {adr[1], 1'b0}; SW = 4'b1111. wdata: SB = byte replicated ×4; SH = half replicated ×2.
- Load extraction: select the lane by adr[1:0]. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- wb_rf_we = rf_wb & (rd != 0) & ~fault. Stores never write the register file.

## Timing
- Reset (asynchronous): state = IDLE. All outputs 0 except ex_ready = 1. An in-flight bus transaction is abandoned and dmem_req drops immediately.
- Accept at edge k:
  - Pass-through: wb_valid in cycle k+1.
  - Store with immediate gnt: REQ in cycle k+1; wb_valid in cycle k+2.
  - Load with immediate gnt and rvalid one cycle later: wb_valid in cycle k+3.
- Each cycle gnt is withheld adds one cycle; each rvalid delay cycle adds one cycle.
- ex_ready is low in REQ and WAIT. A new instruction can be accepted in the same cycle as a wb beat, provided the state is IDLE.
- wb_valid is a single-cycle pulse with no back-pressure. wb_data and wb_rd are held until the next beat.
- rvalid received outside WAIT is ignored.

## Structure
- Shared package (mem_stage_pkg):
  - control-word field bit positions;
  - wb_src encodings (00 ALU, 01 MEM);
  - funct3 width codes;
  - FSM state enum.
- Sub-module load_store_align (combinational): computes be, wdata, misaligned/illegal flags and the extended load data from funct3, adr[1:0], store data and rdata.

## Test plan
- ALU op (rf_wb = 1, rd = 5, ALU_result = 0x0000_1234) accepted at edge k -> wb_valid = 1, wb_rd = 5, wb_data = 0x1234, wb_rf_we = 1 in cycle k+1; no dmem_req.
- SB with adr = 0x103, data = 0xAB, gnt delayed 2 cycles -> dmem_addr = 0x100, be = 1000, wdata = 0xABABABAB held for 3 cycles; ex_ready = 0 throughout; wb_rf_we = 0.
- LB at adr = 0x202, rdata = 0x0080_0000 -> wb_data = 0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- LW at adr = 0x206 -> no dmem_req; mem_fault = 1 and wb_valid = 1 with wb_rf_we = 0 in cycle k+1.
- Load with rd = 0 -> the bus transaction completes; wb_rf_we = 0.
- rst_n asserted during WAIT -> dmem_req = 0, state IDLE, ex_ready = 1 immediately; a late rvalid after reset produces no wb beat.
